// File: rtl/ff_share_arbiter.sv
// ff_share_arbiter
//
// Serialises writes from N producers into one shared W-bit register. The
// register is granted round-robin with a valid/ready handshake. After each
// accepted write, an optional occupancy window of HOLD cycles follows. During
// that window the register holds its value and no new write is granted.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous reset, active-high
//   req_valid  in   N        bit i: requester i offers its data slice
//   req_data   in   N*W      requester i data at [i*W +: W]
//   req_ready  out  N        one-hot or zero, combinational; bit i = i accepted
//   q          out  W        shared register contents
//   q_valid    out  1        one-cycle pulse: q updated this cycle
//   q_owner    out  OW       index of the requester that last wrote q
//   busy       out  1        high while the hold window is active
module ff_share_arbiter #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int HOLD = 2,
  localparam int OW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic [W-1:0]   q,
  output logic           q_valid,
  output logic [OW-1:0]  q_owner,
  output logic           busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  localparam bit       HAS_HOLD  = (HOLD > 0);
  // Loaded on the accept edge. The counter then reaches zero after
  // HOLD-1 decrements, which gives exactly HOLD busy cycles.
  localparam logic [7:0] HOLD_INIT = (HOLD > 0) ? 8'(HOLD - 1) : 8'd0;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [OW-1:0] last_q, last_d;
  logic [W-1:0]  data_q, data_d;
  logic [OW-1:0] owner_q, owner_d;
  logic          qv_q, qv_d;

  logic          win_found;
  logic [OW-1:0] win_idx;
  logic          accept;
  int            scan;

  // ------------------------------------------------------------------
  // Round-robin scan starting just after the last winner.
  // The scan wraps modulo N, so last=N-1 starts the scan at requester 0.
  // It uses only req_valid and the pointer; data never affects the grant.
  // ------------------------------------------------------------------
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    for (int k = 1; k <= N; k++) begin
      scan = int'(last_q) + k;
      if (scan >= N) scan = scan - N;
      if (!win_found && req_valid[scan]) begin
        win_found = 1'b1;
        win_idx   = OW'(scan);
      end
    end
  end

  // A grant is only offered in IDLE. A granted requester is valid by
  // construction, so the grant itself is the accept.
  assign accept = (state_q == S_IDLE) && win_found;

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      last_q  <= OW'(N - 1);
      data_q  <= '0;
      owner_q <= '0;
      qv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      qv_q    <= qv_d;
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && HAS_HOLD) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_INIT;
        end
      end
      S_HOLD: begin
        // The zero test comes before the decrement, so the counter never wraps.
        if (cnt_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Shared register, owner and pointer change only on an accept.
  // A withdrawn or ungranted request leaves all of them untouched.
  always_comb begin
    data_d  = data_q;
    owner_d = owner_q;
    last_d  = last_q;
    qv_d    = 1'b0;
    if (accept) begin
      data_d  = req_data[int'(win_idx)*W +: W];
      owner_d = win_idx;
      last_d  = win_idx;
      qv_d    = 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Output logic
  // ------------------------------------------------------------------
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win_idx] = 1'b1;
    busy = (state_q == S_HOLD);
  end

  assign q       = data_q;
  assign q_valid = qv_q;
  assign q_owner = owner_q;

endmodule

// File: tb/tb_ff_share_arbiter.sv
module tb_ff_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;

  // HOLD=2 instance: single, skip, withdrawal
  logic [3:0] a_ready; logic [7:0] a_q; logic a_qv; logic [1:0] a_own; logic a_busy;
  // HOLD=0 instance: rotation
  logic [3:0] b_ready; logic [7:0] b_q; logic b_qv; logic [1:0] b_own; logic b_busy;
  // HOLD=5 instance: reset mid-hold
  logic [3:0] c_ready; logic [7:0] c_q; logic c_qv; logic [1:0] c_own; logic c_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ff_share_arbiter #(.N(4), .W(8), .HOLD(2)) u_h2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(a_ready), .q(a_q), .q_valid(a_qv), .q_owner(a_own), .busy(a_busy));

  ff_share_arbiter #(.N(4), .W(8), .HOLD(0)) u_h0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(b_ready), .q(b_q), .q_valid(b_qv), .q_owner(b_own), .busy(b_busy));

  ff_share_arbiter #(.N(4), .W(8), .HOLD(5)) u_h5 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(c_ready), .q(c_q), .q_valid(c_qv), .q_owner(c_own), .busy(c_busy));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'($urandom_range(1, 15));
    // slice3=44, slice2=A5, slice1=22, slice0=11
    req_data  = 32'h44A5_2211;

    // ---- Reset with random valids ----
    tick();
    req_valid = 4'($urandom_range(1, 15));
    tick();
    chk("rst_q",      64'(a_q),    64'h0);
    chk("rst_owner",  64'(a_own),  64'h0);
    chk("rst_qvalid", 64'(a_qv),   64'h0);
    chk("rst_busy",   64'(a_busy), 64'h0);
    chk("rst_q_h5",   64'(c_q),    64'h0);
    req_valid = 4'b0000;
    #1;
    chk("rst_ready",  64'(a_ready), 64'h0);

    // ---- Single requester, HOLD=2 ----
    tick();
    rst       = 1'b0;
    req_valid = 4'b0100;
    #1;
    chk("single_ready", 64'(a_ready), 64'b0100);
    tick();
    chk("single_q",     64'(a_q),     64'hA5);
    chk("single_owner", 64'(a_own),   64'd2);
    chk("single_qv",    64'(a_qv),    64'd1);
    chk("single_busy1", 64'(a_busy),  64'd1);
    chk("single_rdy_h", 64'(a_ready), 64'h0);
    req_valid = 4'b0000;
    tick();
    chk("single_qv_off", 64'(a_qv),   64'd0);
    chk("single_busy2",  64'(a_busy), 64'd1);
    tick();
    chk("single_idle",   64'(a_busy), 64'd0);

    // ---- Skip/fairness: grant 1, then 0011 -> 0 then 1 ----
    req_valid = 4'b0010;
    #1;
    chk("skip_rdy1", 64'(a_ready), 64'b0010);
    tick();
    chk("skip_own1", 64'(a_own), 64'd1);
    req_valid = 4'b0011;
    #1;
    chk("skip_hold_rdy", 64'(a_ready), 64'h0);
    tick();
    tick();
    chk("skip_rdy0", 64'(a_ready), 64'b0001);
    tick();
    chk("skip_own0", 64'(a_own), 64'd0);
    chk("skip_q0",   64'(a_q),   64'h11);
    tick();
    tick();
    chk("skip_rdy1b", 64'(a_ready), 64'b0010);
    tick();
    chk("skip_own1b", 64'(a_own), 64'd1);
    chk("skip_q1b",   64'(a_q),   64'h22);

    // ---- Withdrawal during HOLD ----
    req_valid = 4'b1000;
    #1;
    chk("wd_hold_rdy", 64'(a_ready), 64'h0);
    tick();
    req_valid = 4'b0000;
    tick();
    chk("wd_idle_busy", 64'(a_busy),  64'd0);
    chk("wd_idle_rdy",  64'(a_ready), 64'h0);
    tick();
    chk("wd_q",     64'(a_q),   64'h22);
    chk("wd_owner", 64'(a_own), 64'd1);
    chk("wd_qv",    64'(a_qv),  64'd0);
    // The pointer is still at 1, so with all requesters valid the scan picks 2.
    req_valid = 4'b1111;
    #1;
    chk("wd_ptr", 64'(a_ready), 64'b0100);

    // ---- Rotation, HOLD=0 ----
    req_valid = 4'b0000;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("rot_rdy0", 64'(b_ready), 64'b0001);
    for (int i = 0; i < 5; i++) begin
      logic [1:0] eo;
      logic [7:0] eq;
      logic [31:0] dcopy;
      eo    = 2'(i % 4);
      dcopy = req_data;
      eq    = dcopy[8*eo +: 8];
      tick();
      chk("rot_owner", 64'(b_own),  64'(eo));
      chk("rot_q",     64'(b_q),    64'(eq));
      chk("rot_qv",    64'(b_qv),   64'd1);
      chk("rot_busy",  64'(b_busy), 64'd0);
      chk("rot_rdy",   64'(b_ready), 64'(4'b0001 << ((i + 1) % 4)));
    end

    // ---- Reset mid-HOLD, HOLD=5 ----
    req_valid = 4'b0000;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
    req_valid = 4'b0100;
    tick();
    chk("mh_q",     64'(c_q),    64'hA5);
    chk("mh_busy1", 64'(c_busy), 64'd1);
    req_valid = 4'b0000;
    tick();
    chk("mh_busy2", 64'(c_busy), 64'd1);
    rst = 1'b1;
    tick();
    chk("mh_rst_busy",  64'(c_busy), 64'd0);
    chk("mh_rst_q",     64'(c_q),    64'h0);
    chk("mh_rst_owner", 64'(c_own),  64'd0);
    rst       = 1'b0;
    req_valid = 4'b0001;
    #1;
    chk("mh_after_rdy", 64'(c_ready), 64'b0001);
    tick();
    chk("mh_after_q",    64'(c_q),    64'h11);
    chk("mh_after_qv",   64'(c_qv),   64'd1);
    chk("mh_after_busy", 64'(c_busy), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
